fb_bram_arbiter: RTL
====================

Name: fb_bram_arbiter

Overview:
- Shares the single-port 16-bit frame-buffer sync RAM (1-cycle read latency) among three requesters:
  - the VGA pixel fetch path;
  - the SD byte-pair writer;
  - the checksum reader.
- Replaces the static state-based address mux, so SD reloads and checksum scans can run while video is active.
- VGA has priority. Starvation guards guarantee the two background ports forward progress.

Parameters:
- ADDR_W, 15, RAM word-address width.
- DATA_W, 16, RAM data width.
- STARVE_LIMIT, 64, cycles a background request may wait before it pre-empts one VGA slot (legal range 1..255).

Ports:
- clk  in  1  single clock (25 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request; high every active-video cycle.
- vga_addr  in  ADDR_W  VGA read address.
- vga_rdata  out  DATA_W  VGA pixel data; holds the last good word when a slot is lost.
- vga_rvalid  out  1  vga_rdata is fresh this cycle.
- wr_req  in  1  SD writer request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  write accepted this cycle.
- ck_req  in  1  checksum read request.
- ck_addr  in  ADDR_W  checksum read address.
- ck_gnt  out  1  read issued this cycle.
- ck_rdata  out  DATA_W  checksum read data.
- ck_rvalid  out  1  ck_rdata valid.
- vga_drop  out  1  registered pulse: previous cycle's VGA request was pre-empted.
- ram_addr  out  ADDR_W  to RAM.
- ram_din  out  DATA_W  to RAM.
- ram_we  out  1  to RAM.
- ram_dout  in  DATA_W  from RAM; valid the cycle after the address.

Behaviour:
- Arbitration is combinational each cycle. ram_addr, ram_din, ram_we, wr_gnt and ck_gnt reflect the winner in the same cycle.
- Requester rule: req, addr and data stay stable until the gnt cycle; a port may re-request back-to-back.
- Priority, evaluated in order:
  - (1) a starved background port, i.e. its wait counter == STARVE_LIMIT. If both are starved, the round-robin pointer chooses.
  - (2) vga_req.
  - (3) wr_req / ck_req, chosen by the round-robin pointer when both are high.
- No VGA gnt port: VGA is granted whenever it wins and never waits.
- Round-robin pointer:
  - 1 bit; reset value selects wr.
  - After any background grant, the pointer points at the other background port.
- Wait counters, one 8-bit counter per background port:
  - increment while req && !gnt, saturating at STARVE_LIMIT;
  - clear on gnt or when req is low.
- Read path:
  - vga_rvalid and ck_rvalid are registered copies of "VGA won" and ck_gnt (latency 1).
  - ck_rdata = ram_dout.
  - vga_rdata = ram_dout when vga_rvalid, else vga_hold_q.
  - vga_hold_q captures ram_dout on every vga_rvalid cycle.
- Write path:
  - ram_we = wr_gnt; ram_din = wr_data.
  - A write has no read response.
- Idle (no requests): ram_addr = vga_addr, ram_we = 0.
- vga_drop is a registered copy of (vga_req && a background port won).
- Reset, asynchronous and at any time, including mid-scan:
  - combinational outputs: all gnt = 0, ram_we = 0;
  - registered state: rvalids, vga_drop, vga_hold_q, counters and pointer are cleared;
  - pending requests restart arbitration after deassertion, with counters at 0.

Optional Feature:
- FB_ARB_STATS_EN adds outputs stat_drops[15:0] and stat_wr_grants[15:0].
  - Both are saturating counters, reset to 0.
  - stat_drops increments on each vga_drop pulse.
  - stat_wr_grants increments on each wr_gnt.
  - Without the macro these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Only wr_req, addr 0x0010, data 0xA5C3 -> wr_gnt and ram_we high the same cycle, ram_addr=0x0010; a later ck read of 0x0010 returns ck_rdata=0xA5C3 with ck_rvalid one cycle after ck_gnt.
- wr_req and ck_req held high together, vga_req low -> grants alternate wr, ck, wr, ck, starting with wr after reset.
- vga_req high continuously, ck_req high from cycle 0, STARVE_LIMIT=64 -> ck_gnt first at cycle 64; vga_drop pulses at cycle 65; vga_rdata in cycle 65 equals the cycle-64 value.
- vga_req continuous, wr and ck both high -> each is granted once per 65 cycles, never in the same cycle; VGA loses exactly those slots.
- reset_n low mid-burst with ck_gnt just issued -> ck_rvalid, vga_rvalid, vga_drop and counters are 0 immediately; wr_gnt and ram_we are 0 while reset is held.
- With FB_ARB_STATS_EN, 3 forced drops and 5 writes -> stat_drops=3, stat_wr_grants=5; stat_drops saturates at 0xFFFF.

Source files
------------

// File: rtl/fb_bram_arbiter_if.sv
// Frame-buffer RAM arbiter bus: VGA fetch, SD writer, checksum reader and RAM side.
interface fb_bram_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vga_drop;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              ck_req;
    logic [ADDR_W-1:0] ck_addr;
    logic              ck_gnt;
    logic [DATA_W-1:0] ck_rdata;
    logic              ck_rvalid;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter side
    modport slave (
        input  vga_req, vga_addr, wr_req, wr_addr, wr_data, ck_req, ck_addr, ram_dout,
        output vga_rdata, vga_rvalid, vga_drop, wr_gnt, ck_gnt, ck_rdata, ck_rvalid,
               ram_addr, ram_din, ram_we
    );

    // Requester / RAM side
    modport master (
        output vga_req, vga_addr, wr_req, wr_addr, wr_data, ck_req, ck_addr, ram_dout,
        input  vga_rdata, vga_rvalid, vga_drop, wr_gnt, ck_gnt, ck_rdata, ck_rvalid,
               ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/fb_bram_arbiter.sv
// Single-port frame-buffer RAM arbiter: VGA has priority, SD writer and checksum
// reader share the leftover slots round-robin and pre-empt one VGA slot once they
// have waited STARVE_LIMIT cycles.
// Optional macro FB_ARB_STATS_EN adds saturating drop / write-grant counters.
module fb_bram_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fb_bram_arbiter_if.slave     bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]          stat_drops,
    output logic [15:0]          stat_wr_grants
`endif
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {SEL_NONE, SEL_VGA, SEL_WR, SEL_CK} sel_e;

    sel_e              sel_c;
    logic              wr_starved_c;
    logic              ck_starved_c;
    logic              wr_gnt_c;
    logic              ck_gnt_c;
    logic [ADDR_W-1:0] ram_addr_c;

    logic [CNT_W-1:0]  wr_wait_q, wr_wait_d;
    logic [CNT_W-1:0]  ck_wait_q, ck_wait_d;
    logic              rr_ck_q, rr_ck_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic              ck_rvalid_q, ck_rvalid_d;
    logic              vga_drop_q, vga_drop_d;
    logic [DATA_W-1:0] vga_hold_q, vga_hold_d;

    // Pick this cycle's RAM owner: starved background, then VGA, then round-robin
    always_comb begin
        wr_starved_c = bus.wr_req && (wr_wait_q == LIMIT);
        ck_starved_c = bus.ck_req && (ck_wait_q == LIMIT);
        sel_c        = SEL_NONE;
        if (!reset_n) begin
            sel_c = SEL_NONE;
        end else if (wr_starved_c && ck_starved_c) begin
            sel_c = rr_ck_q ? SEL_CK : SEL_WR;
        end else if (wr_starved_c) begin
            sel_c = SEL_WR;
        end else if (ck_starved_c) begin
            sel_c = SEL_CK;
        end else if (bus.vga_req) begin
            sel_c = SEL_VGA;
        end else if (bus.wr_req && bus.ck_req) begin
            sel_c = rr_ck_q ? SEL_CK : SEL_WR;
        end else if (bus.wr_req) begin
            sel_c = SEL_WR;
        end else if (bus.ck_req) begin
            sel_c = SEL_CK;
        end
    end

    // RAM address mux; idle cycles keep the VGA address on the bus
    always_comb begin
        wr_gnt_c = (sel_c == SEL_WR);
        ck_gnt_c = (sel_c == SEL_CK);
        ram_addr_c = bus.vga_addr;
        if (wr_gnt_c) begin
            ram_addr_c = bus.wr_addr;
        end else if (ck_gnt_c) begin
            ram_addr_c = bus.ck_addr;
        end
    end

    assign bus.wr_gnt   = wr_gnt_c;
    assign bus.ck_gnt   = ck_gnt_c;
    assign bus.ram_we   = wr_gnt_c;
    assign bus.ram_din  = bus.wr_data;
    assign bus.ram_addr = ram_addr_c;

    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.ck_rvalid  = ck_rvalid_q;
    assign bus.vga_drop   = vga_drop_q;
    assign bus.ck_rdata   = bus.ram_dout;
    assign bus.vga_rdata  = vga_rvalid_q ? bus.ram_dout : vga_hold_q;

    // Next-state: wait counters, round-robin pointer, read-response tracking
    always_comb begin
        wr_wait_d = '0;
        if (bus.wr_req && !wr_gnt_c) begin
            wr_wait_d = (wr_wait_q == LIMIT) ? wr_wait_q : wr_wait_q + CNT_W'(1);
        end
        ck_wait_d = '0;
        if (bus.ck_req && !ck_gnt_c) begin
            ck_wait_d = (ck_wait_q == LIMIT) ? ck_wait_q : ck_wait_q + CNT_W'(1);
        end
        rr_ck_d = rr_ck_q;
        if (wr_gnt_c) begin
            rr_ck_d = 1'b1;
        end else if (ck_gnt_c) begin
            rr_ck_d = 1'b0;
        end
        vga_rvalid_d = (sel_c == SEL_VGA);
        ck_rvalid_d  = ck_gnt_c;
        vga_drop_d   = bus.vga_req && (wr_gnt_c || ck_gnt_c);
        vga_hold_d   = vga_rvalid_q ? bus.ram_dout : vga_hold_q;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_wait_q    <= '0;
            ck_wait_q    <= '0;
            rr_ck_q      <= 1'b0;
            vga_rvalid_q <= 1'b0;
            ck_rvalid_q  <= 1'b0;
            vga_drop_q   <= 1'b0;
            vga_hold_q   <= '0;
        end else begin
            wr_wait_q    <= wr_wait_d;
            ck_wait_q    <= ck_wait_d;
            rr_ck_q      <= rr_ck_d;
            vga_rvalid_q <= vga_rvalid_d;
            ck_rvalid_q  <= ck_rvalid_d;
            vga_drop_q   <= vga_drop_d;
            vga_hold_q   <= vga_hold_d;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stat_drops_q, stat_drops_d;
    logic [15:0] stat_wr_grants_q, stat_wr_grants_d;

    // Saturating event counters
    always_comb begin
        stat_drops_d = stat_drops_q;
        if (vga_drop_q && (stat_drops_q != 16'hFFFF)) begin
            stat_drops_d = stat_drops_q + 16'd1;
        end
        stat_wr_grants_d = stat_wr_grants_q;
        if (wr_gnt_c && (stat_wr_grants_q != 16'hFFFF)) begin
            stat_wr_grants_d = stat_wr_grants_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_drops_q     <= '0;
            stat_wr_grants_q <= '0;
        end else begin
            stat_drops_q     <= stat_drops_d;
            stat_wr_grants_q <= stat_wr_grants_d;
        end
    end

    assign stat_drops     = stat_drops_q;
    assign stat_wr_grants = stat_wr_grants_q;
`endif
endmodule
